// File: rtl/uart_pkg.sv
// Shared encodings for the UART register bank and its bus initiator.
package uart_pkg;

  // Host command opcodes
  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_POLL  = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  // Initiator FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_GAP    = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Register map of the UART bank
  localparam logic [1:0] ADDR_STAT = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_TX   = 2'd2;
  localparam logic [1:0] ADDR_RX   = 2'd3;

endpackage

// File: rtl/uart_reg_initiator.sv
// Command-driven master for the UART register port: turns read/write/poll
// commands into single-cycle register strobes and returns a response.
// Optional feature macro: UART_REG_INITIATOR_POLL_EN (poll op, mask compare,
// GAP state and poll counter); when undefined op 2 is treated as reserved.
module uart_reg_initiator
  import uart_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 2,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [1:0]               cmd_op_i,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]    cmd_data_i,
  input  logic [DATA_WIDTH-1:0]    cmd_mask_i,
  input  logic [TIMEOUT_WIDTH-1:0] poll_limit_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DATA_WIDTH-1:0]    rsp_data_o,
  output logic                     rsp_err_o,
  output logic [ADDR_WIDTH-1:0]    bus_addr_o,
  output logic [DATA_WIDTH-1:0]    bus_data_o,
  output logic                     bus_wr_en_o,
  output logic                     bus_rd_en_o,
  input  logic [DATA_WIDTH-1:0]    bus_data_i
);

  state_e                  state_q, state_d;
  op_e                     op_q, op_d;
  logic                    accept;
  logic                    ready_d, rd_d, wr_d, rsp_valid_d, rsp_err_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   wdata_d, rsp_data_d;

`ifdef UART_REG_INITIATOR_POLL_EN
  logic [DATA_WIDTH-1:0]    cmp_q, cmp_d, mask_q, mask_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                     match, limit_hit;

  // Poll compare and saturating count of non-matching reads
  assign match     = ((bus_data_i ^ cmp_q) & mask_q) == '0;
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + TIMEOUT_WIDTH'(1);
  assign limit_hit = (poll_limit_i != '0) && (cnt_inc == poll_limit_i);
`else
  logic unused_poll;
  assign unused_poll = ^{cmd_mask_i, poll_limit_i};
`endif

  assign accept = cmd_valid_i && cmd_ready_o;

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ready_d     = 1'b0;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    addr_d      = bus_addr_o;
    wdata_d     = bus_data_o;
    rsp_valid_d = rsp_valid_o;
    rsp_data_d  = rsp_data_o;
    rsp_err_d   = rsp_err_o;
`ifdef UART_REG_INITIATOR_POLL_EN
    cmp_d       = cmp_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          ready_d = 1'b0;
          op_d    = op_e'(cmd_op_i);
          addr_d  = cmd_addr_i;
`ifdef UART_REG_INITIATOR_POLL_EN
          cmp_d   = cmd_data_i;
          mask_d  = cmd_mask_i;
          cnt_d   = '0;
`endif
          case (op_e'(cmd_op_i))
            OP_READ: begin
              rd_d    = 1'b1;
              state_d = ST_ACCESS;
            end
            OP_WRITE: begin
              wr_d    = 1'b1;
              wdata_d = cmd_data_i;
              state_d = ST_ACCESS;
            end
`ifdef UART_REG_INITIATOR_POLL_EN
            OP_POLL: begin
              rd_d    = 1'b1;
              state_d = ST_ACCESS;
            end
`endif
            default: begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
              rsp_err_d   = 1'b1;
              state_d     = ST_RESP;
            end
          endcase
        end
      end
      ST_ACCESS: begin
        case (op_q)
          OP_READ: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = bus_data_i;
            rsp_err_d   = 1'b0;
            state_d     = ST_RESP;
          end
          OP_WRITE: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = bus_data_o;
            rsp_err_d   = 1'b0;
            state_d     = ST_RESP;
          end
`ifdef UART_REG_INITIATOR_POLL_EN
          OP_POLL: begin
            if (match) begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = bus_data_i;
              rsp_err_d   = 1'b0;
              state_d     = ST_RESP;
            end else begin
              cnt_d = cnt_inc;
              if (limit_hit) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = bus_data_i;
                rsp_err_d   = 1'b1;
                state_d     = ST_RESP;
              end else begin
                state_d = ST_GAP;
              end
            end
          end
`endif
          default: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            state_d     = ST_RESP;
          end
        endcase
      end
      ST_GAP: begin
        rd_d    = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          ready_d     = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset clears strobes asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      cmd_ready_o <= 1'b0;
      bus_rd_en_o <= 1'b0;
      bus_wr_en_o <= 1'b0;
      bus_addr_o  <= '0;
      bus_data_o  <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
`ifdef UART_REG_INITIATOR_POLL_EN
      cmp_q       <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cmd_ready_o <= ready_d;
      bus_rd_en_o <= rd_d;
      bus_wr_en_o <= wr_d;
      bus_addr_o  <= addr_d;
      bus_data_o  <= wdata_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_data_o  <= rsp_data_d;
      rsp_err_o   <= rsp_err_d;
`ifdef UART_REG_INITIATOR_POLL_EN
      cmp_q       <= cmp_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_reg_initiator.sv
// Directed self-checking bench for uart_reg_initiator with a small
// register-bank model driving bus_data_i.
module tb_uart_reg_initiator;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i = 2'd0;
  logic [1:0]  cmd_addr_i = 2'd0;
  logic [31:0] cmd_data_i = '0;
  logic [31:0] cmd_mask_i = '0;
  logic [15:0] poll_limit_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic [1:0]  bus_addr_o;
  logic [31:0] bus_data_o;
  logic        bus_wr_en_o;
  logic        bus_rd_en_o;
  logic [31:0] bus_data_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned cyc = 0, rd_cnt = 0, wr_cnt = 0, viol = 0, stat_reads = 0;
  int unsigned last_rd = 0, prev_rd = 0;
  logic        prev_strobe = 1'b0;
  int unsigned stat_base = 0, set_at = 0;

  always #5 clk = ~clk;

  uart_reg_initiator #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .TIMEOUT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_addr_i(cmd_addr_i),
    .cmd_data_i(cmd_data_i), .cmd_mask_i(cmd_mask_i),
    .poll_limit_i(poll_limit_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
    .bus_wr_en_o(bus_wr_en_o), .bus_rd_en_o(bus_rd_en_o),
    .bus_data_i(bus_data_i)
  );

  // Register bank model: stat returns (reads<<4) with bit0 set from read set_at on
  always_comb begin
    int unsigned n;
    n = stat_reads - stat_base;
    case (bus_addr_o)
      ADDR_STAT: bus_data_i = (n << 4) | ((set_at != 0 && n >= set_at) ? 32'h1 : 32'h0);
      ADDR_CTRL: bus_data_i = 32'h0000_0003;
      ADDR_TX:   bus_data_i = 32'h0000_0000;
      default:   bus_data_i = 32'h0000_00A5;
    endcase
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor sampled mid-cycle
  always @(negedge clk) begin
    if (bus_rd_en_o) begin
      rd_cnt  <= rd_cnt + 1;
      prev_rd <= last_rd;
      last_rd <= cyc;
      if (bus_addr_o == ADDR_STAT) stat_reads <= stat_reads + 1;
    end
    if (bus_wr_en_o) wr_cnt <= wr_cnt + 1;
    if ((bus_rd_en_o || bus_wr_en_o) && prev_strobe) viol <= viol + 1;
    prev_strobe <= bus_rd_en_o || bus_wr_en_o;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  // Present one command and return in the cycle after the handshake
  task automatic send(input logic [1:0] op, input logic [1:0] addr,
                      input logic [31:0] data, input logic [31:0] mask);
    int i;
    i = 0;
    while (!cmd_ready_o && i < 50) begin
      step();
      i++;
    end
    if (!cmd_ready_o) check("cmd_ready_wait", 32'(cmd_ready_o), 32'h1);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_addr_i  = addr;
    cmd_data_i  = data;
    cmd_mask_i  = mask;
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(output int unsigned n);
    n = 0;
    while (!rsp_valid_o && n < 200) begin
      step();
      n++;
    end
    if (!rsp_valid_o) check("rsp_timeout", 32'(rsp_valid_o), 32'h1);
  endtask

  function automatic logic any_out();
    return |{cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
             bus_addr_o, bus_data_o, bus_wr_en_o, bus_rd_en_o};
  endfunction

  // Reset mid-operation: outputs clear at once and nothing resumes afterwards
  task automatic reset_midway(input string tag);
    int unsigned r0, w0, seen;
    #1 rst_i = 1'b1;
    #1;
    check({tag, "_outs_zero"}, 32'(any_out()), 32'h0);
    r0 = rd_cnt;
    w0 = wr_cnt;
    step();
    step();
    rst_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid_o || bus_rd_en_o || bus_wr_en_o) seen++;
    end
    check({tag, "_no_activity"}, seen + (rd_cnt - r0) + (wr_cnt - w0), 32'h0);
    send(OP_READ, ADDR_RX, 32'h0, 32'h0);
    step();
    check({tag, "_read_after"}, rsp_data_o, 32'h0000_00A5);
    step();
  endtask

  initial begin
    int unsigned n, r0, w0, bad;

    #1;
    check("reset_outs", 32'(any_out()), 32'h0);
    step();
    step();
    rst_i = 1'b0;
    step();
    check("ready_after_reset", 32'(cmd_ready_o), 32'h1);

    // Write ctrl = 0x7F
    send(OP_WRITE, ADDR_CTRL, 32'h0000_007F, 32'h0);
    check("wr_strobe", {29'h0, cmd_ready_o, bus_wr_en_o, bus_rd_en_o}, 32'h2);
    check("wr_addr", 32'(bus_addr_o), 32'h1);
    check("wr_data", bus_data_o, 32'h0000_007F);
    check("wr_no_rsp_yet", 32'(rsp_valid_o), 32'h0);
    step();
    check("wr_rsp", {30'h0, rsp_valid_o, rsp_err_o}, 32'h2);
    check("wr_rsp_data", rsp_data_o, 32'h0000_007F);
    check("wr_strobe_off", 32'(bus_wr_en_o), 32'h0);
    step();
    check("wr_resp_one_cycle", {30'h0, rsp_valid_o, cmd_ready_o}, 32'h1);

    // Read rx
    send(OP_READ, ADDR_RX, 32'hDEAD_BEEF, 32'h0);
    check("rd_strobe", {29'h0, bus_addr_o, bus_rd_en_o}, 32'h7);
    step();
    check("rd_rsp", {30'h0, rsp_valid_o, rsp_err_o}, 32'h2);
    check("rd_rsp_data", rsp_data_o, 32'h0000_00A5);
    check("rd_keeps_wdata", bus_data_o, 32'h0000_007F);
    step();

    // Reserved op with back-pressure
    rsp_ready_i = 1'b0;
    r0 = rd_cnt;
    w0 = wr_cnt;
    send(OP_RSVD, ADDR_TX, 32'h0000_1234, 32'h0);
    check("rsvd_rsp", {30'h0, rsp_valid_o, rsp_err_o}, 32'h3);
    check("rsvd_data", rsp_data_o, 32'h0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!(rsp_valid_o && rsp_err_o && rsp_data_o == 32'h0 && !cmd_ready_o)) bad++;
    end
    check("rsvd_hold_stable", bad, 32'h0);
    rsp_ready_i = 1'b1;
    step();
    check("rsvd_released", {30'h0, rsp_valid_o, cmd_ready_o}, 32'h1);
    check("rsvd_no_strobe", (rd_cnt - r0) + (wr_cnt - w0), 32'h0);

`ifdef UART_REG_INITIATOR_POLL_EN
    // Poll stat bit0, set on the third read
    stat_base = stat_reads;
    set_at    = 3;
    poll_limit_i = 16'd0;
    r0 = rd_cnt;
    send(OP_POLL, ADDR_STAT, 32'h1, 32'h1);
    wait_rsp(n);
    check("poll_latency", n, 32'd5);
    check("poll_err", 32'(rsp_err_o), 32'h0);
    check("poll_data", rsp_data_o, 32'h0000_0031);
    check("poll_reads", rd_cnt - r0, 32'd3);
    check("poll_period", last_rd - prev_rd, 32'd2);
    step();

    // Poll timeout after four reads
    stat_base = stat_reads;
    set_at    = 0;
    poll_limit_i = 16'd4;
    r0 = rd_cnt;
    send(OP_POLL, ADDR_STAT, 32'h1, 32'h1);
    wait_rsp(n);
    check("timeout_latency", n, 32'd7);
    check("timeout_err", 32'(rsp_err_o), 32'h1);
    check("timeout_data", rsp_data_o, 32'h0000_0040);
    check("timeout_reads", rd_cnt - r0, 32'd4);
    step();

    // Reset during a poll GAP on rx (bit8 never set)
    poll_limit_i = 16'd0;
    send(OP_POLL, ADDR_RX, 32'h100, 32'h100);
    step();
    check("gap_idle", {30'h0, bus_rd_en_o, rsp_valid_o}, 32'h0);
    reset_midway("rst_gap");
`else
    // Op 2 is reserved in this build
    r0 = rd_cnt;
    send(OP_POLL, ADDR_STAT, 32'h1, 32'h1);
    check("poll_as_rsvd", {30'h0, rsp_valid_o, rsp_err_o}, 32'h3);
    check("poll_as_rsvd_data", rsp_data_o, 32'h0);
    check("poll_as_rsvd_no_rd", rd_cnt - r0, 32'h0);
    step();

    // Reset during a write strobe
    send(OP_WRITE, ADDR_TX, 32'h0000_0055, 32'h0);
    check("wr_before_rst", 32'(bus_wr_en_o), 32'h1);
    reset_midway("rst_access");
`endif

    check("no_back_to_back_strobes", viol, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
